// File: rtl/counter_pkg.sv
// Shared types for the count delta sampler.
// Holds the sampler state encoding used by the FSM and by anything that
// inspects it.
package counter_pkg;

  typedef enum logic [1:0] {
    UNPRIMED = 2'd0,
    PRIMED   = 2'd1,
    PENDING  = 2'd2
  } sampler_state_e;

endpackage : counter_pkg

// File: rtl/delta_sat_accum.sv
// Saturating adder for the pending delta.
// Ports:
//   a, b    : DWIDTH-bit operands
//   sum     : a+b, clipped to all-ones when the true sum does not fit
//   clipped : 1 when clipping occurred
module delta_sat_accum #(
  parameter int DWIDTH = 6
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] sum,
  output logic              clipped
);

  logic [DWIDTH:0] full;

  // One extra bit catches the carry out; a carry means the sum exceeded 2**DWIDTH-1.
  assign full    = {1'b0, a} + {1'b0, b};
  assign clipped = full[DWIDTH];
  assign sum     = full[DWIDTH] ? {DWIDTH{1'b1}} : full[DWIDTH-1:0];

endmodule : delta_sat_accum

// File: rtl/count_delta_sampler.sv
// Samples an external free-running count and reports the modular difference
// between successive samples on a valid/ready output. While downstream stalls,
// new deltas are summed (saturating) into the pending value.
// Ports:
//   clk_i, rst_ni        : clock, async active-low reset
//   clear_i              : sync clear, highest priority, discards pending data
//   en_i, sample_i       : sample strobe (both must be high)
//   down_i               : source counts down (delta = last - count_i)
//   count_i  [WIDTH]     : external count value
//   delta_o  [DWIDTH]    : pending accumulated delta
//   valid_o / ready_i    : output handshake
//   saturated_o          : accumulation clipped at 2**DWIDTH-1
//   primed_o             : reference sample held
//
// state    | meaning
// UNPRIMED | no reference sample yet; the first sample only primes
// PRIMED   | reference held, no delta pending
// PENDING  | delta_o valid, waiting for ready_i
module count_delta_sampler
  import counter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DWIDTH     = 6,
  parameter bit STICKY_SAT = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic              sample_i,
  input  logic              down_i,
  input  logic [WIDTH-1:0]  count_i,
  output logic [DWIDTH-1:0] delta_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              saturated_o,
  output logic              primed_o
);

  generate
    if (DWIDTH < WIDTH) begin : g_bad_width
      $error("count_delta_sampler: DWIDTH must be >= WIDTH");
    end
  endgenerate

  sampler_state_e    state;
  logic [WIDTH-1:0]  last;
  logic              smp;
  logic [WIDTH-1:0]  diff;
  logic [DWIDTH-1:0] d_ext;
  logic [DWIDTH-1:0] acc_sum;
  logic              acc_clip;

  assign smp   = en_i & sample_i;
  // WIDTH-bit subtraction gives the modular difference, so counter wrap is free.
  assign diff  = down_i ? (last - count_i) : (count_i - last);
  assign d_ext = DWIDTH'(diff);

  delta_sat_accum #(.DWIDTH(DWIDTH)) u_accum (
    .a       (delta_o),
    .b       (d_ext),
    .sum     (acc_sum),
    .clipped (acc_clip)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= UNPRIMED;
      last        <= '0;
      delta_o     <= '0;
      valid_o     <= 1'b0;
      saturated_o <= 1'b0;
      primed_o    <= 1'b0;
    end else if (clear_i) begin
      state       <= UNPRIMED;
      delta_o     <= '0;
      valid_o     <= 1'b0;
      saturated_o <= 1'b0;
      primed_o    <= 1'b0;
    end else begin
      if (smp) last <= count_i;
      case (state)
        UNPRIMED: begin
          if (smp) begin
            state    <= PRIMED;
            primed_o <= 1'b1;
          end
        end
        PRIMED: begin
          if (smp) begin
            state   <= PENDING;
            delta_o <= d_ext;
            valid_o <= 1'b1;
          end
        end
        PENDING: begin
          if (ready_i) begin
            // Non-sticky saturation flags the value being transferred now.
            if (!STICKY_SAT) saturated_o <= 1'b0;
            if (smp) begin
              delta_o <= d_ext;
            end else begin
              state   <= PRIMED;
              delta_o <= '0;
              valid_o <= 1'b0;
            end
          end else if (smp) begin
            delta_o <= acc_sum;
            if (acc_clip) saturated_o <= 1'b1;
          end
        end
        default: begin
          state    <= UNPRIMED;
          delta_o  <= '0;
          valid_o  <= 1'b0;
          primed_o <= 1'b0;
        end
      endcase
    end
  end

endmodule : count_delta_sampler

// File: tb/tb_count_delta_sampler.sv
module tb_count_delta_sampler;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       clear_i = 1'b0;
  logic       en_i = 1'b0;
  logic       sample_i = 1'b0;
  logic       down_i = 1'b0;
  logic [3:0] count_i = '0;
  logic       ready_i = 1'b1;
  logic [5:0] delta_o, delta_s;
  logic       valid_o, valid_s;
  logic       saturated_o, saturated_s;
  logic       primed_o, primed_s;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  count_delta_sampler #(.WIDTH(4), .DWIDTH(6), .STICKY_SAT(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .en_i(en_i),
    .sample_i(sample_i), .down_i(down_i), .count_i(count_i),
    .delta_o(delta_o), .valid_o(valid_o), .ready_i(ready_i),
    .saturated_o(saturated_o), .primed_o(primed_o)
  );

  count_delta_sampler #(.WIDTH(4), .DWIDTH(6), .STICKY_SAT(1'b1)) dut_sticky (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .en_i(en_i),
    .sample_i(sample_i), .down_i(down_i), .count_i(count_i),
    .delta_o(delta_s), .valid_o(valid_s), .ready_i(ready_i),
    .saturated_o(saturated_s), .primed_o(primed_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp(input logic [3:0] c, input logic dn);
    en_i = 1'b1; sample_i = 1'b1; count_i = c; down_i = dn;
    step();
    en_i = 1'b0; sample_i = 1'b0; down_i = 1'b0;
  endtask

  initial begin
    // reset
    #2 rst_ni = 1'b0;
    #2;
    chk("rst_valid", valid_o, 0);
    chk("rst_delta", delta_o, 0);
    chk("rst_primed", primed_o, 0);
    chk("rst_sat", saturated_o, 0);
    #4 rst_ni = 1'b1;
    step();

    // 1: prime then first delta
    smp(4'd3, 1'b0);
    chk("t1_primed", primed_o, 1);
    chk("t1_novalid", valid_o, 0);
    smp(4'd7, 1'b0);
    chk("t1_valid", valid_o, 1);
    chk("t1_delta", delta_o, 4);
    step();
    chk("t1_xfer_valid", valid_o, 0);
    chk("t1_xfer_delta", delta_o, 0);

    // 2: wrap up and wrap down
    smp(4'd14, 1'b0);
    chk("t2_pre_delta", delta_o, 7);
    step();
    smp(4'd2, 1'b0);
    chk("t2_wrap_up", delta_o, 4);
    step();
    smp(4'd14, 1'b1);
    chk("t2_wrap_down", delta_o, 4);
    step();

    // 3: accumulate under stall, saturate, transfer
    ready_i = 1'b0;
    smp(4'd13, 1'b0);
    chk("t3_acc1", delta_o, 15);
    smp(4'd12, 1'b0);
    smp(4'd11, 1'b0);
    smp(4'd10, 1'b0);
    chk("t3_acc4", delta_o, 60);
    chk("t3_nosat", saturated_o, 0);
    smp(4'd9, 1'b0);
    chk("t3_clip", delta_o, 63);
    chk("t3_sat", saturated_o, 1);
    chk("t3_sat_sticky", saturated_s, 1);
    step();
    chk("t3_hold", delta_o, 63);
    chk("t3_hold_valid", valid_o, 1);
    ready_i = 1'b1;
    step();
    chk("t3_after_valid", valid_o, 0);
    chk("t3_after_sat", saturated_o, 0);
    chk("t3_after_sat_sticky", saturated_s, 1);

    // 4: handshake and sample in the same cycle
    smp(4'd14, 1'b0);
    chk("t4_delta5", delta_o, 5);
    smp(4'd1, 1'b0);
    chk("t4_delta3", delta_o, 3);
    chk("t4_valid", valid_o, 1);
    step();
    chk("t4_done_valid", valid_o, 0);

    // 5: clear with a same-cycle sample
    smp(4'd10, 1'b0);
    chk("t5_delta9", delta_o, 9);
    clear_i = 1'b1;
    smp(4'd5, 1'b0);
    clear_i = 1'b0;
    chk("t5_clr_valid", valid_o, 0);
    chk("t5_clr_primed", primed_o, 0);
    chk("t5_clr_delta", delta_o, 0);
    chk("t5_clr_sat_sticky", saturated_s, 0);
    smp(4'd7, 1'b0);
    chk("t5_reprime", primed_o, 1);
    chk("t5_reprime_novalid", valid_o, 0);
    smp(4'd9, 1'b0);
    chk("t5_delta2", delta_o, 2);
    chk("t5_valid", valid_o, 1);

    // 6: async reset while valid, then disabled samples
    ready_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", valid_o, 0);
    chk("t6_rst_delta", delta_o, 0);
    chk("t6_rst_primed", primed_o, 0);
    #1 rst_ni = 1'b1;
    ready_i = 1'b1;
    en_i = 1'b0; sample_i = 1'b1; count_i = 4'd8;
    step();
    step();
    sample_i = 1'b0;
    chk("t6_en0_primed", primed_o, 0);
    chk("t6_en0_valid", valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_count_delta_sampler
